// File: rtl/y86_instr_encoder.sv
// Serialises one decoded Y86 instruction per handshake into byte-wide instruction memory.
// Optional build macro ENC_CHECK_EN: reject invalid icode/ifun combinations like an overflow.
module y86_instr_encoder #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              base_load,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        icode,
    input  logic [3:0]        ifun,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic [63:0]       valC,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic [ADDR_W:0]   wr_addr,
    output logic              done,
    output logic              err,
    output logic              dbg_state
);

    // Handshake: an instruction is taken on a rising edge where in_valid && in_ready;
    // in_valid may be held across cycles, in_ready never depends on in_valid.
    // wr_addr is one bit wider than mem_addr so a completely full memory reads 2**ADDR_W.

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t r_state, w_nxt_state;

    logic [3:0]        r_idx, w_nxt_idx;
    logic [3:0]        r_len;
    logic [3:0]        r_icode, r_ifun, r_ra, r_rb;
    logic [63:0]       r_valc;
    logic              r_mem_we, w_nxt_we;
    logic [ADDR_W-1:0] r_mem_addr, w_nxt_addr;
    logic [7:0]        r_mem_wdata, w_nxt_wdata;
    logic [ADDR_W:0]   r_wr_addr, w_nxt_wr_addr;
    logic              r_done, w_nxt_done;
    logic              r_err, w_nxt_err;
    logic              w_cap;

    logic [3:0]        w_len;
    logic [ADDR_W:0]   w_sum;
    logic [ADDR_W:0]   w_full;
    logic              w_ovf;
    logic              w_bad;

    function automatic logic f_has_reg(input logic [3:0] ic);
        case (ic)
            4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd10, 4'd11: return 1'b1;
            default:                                     return 1'b0;
        endcase
    endfunction

    function automatic logic f_has_valc(input logic [3:0] ic);
        case (ic)
            4'd3, 4'd4, 4'd5, 4'd7, 4'd8: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] f_len(input logic [3:0] ic);
        return 4'd1 + {3'b000, f_has_reg(ic)} + {f_has_valc(ic), 3'b000};
    endfunction

    // Byte idx of an instruction: opcode, optional register byte, then valC MSB first.
    function automatic logic [7:0] f_byte(input logic [3:0] idx, input logic [3:0] ic,
                                          input logic [3:0] fn, input logic [3:0] ra,
                                          input logic [3:0] rb, input logic [63:0] vc);
        logic [2:0] k;
        if (idx == 4'd0) return {ic, fn};
        if (f_has_reg(ic) && idx == 4'd1) return {ra, rb};
        k = idx[2:0] - (f_has_reg(ic) ? 3'd2 : 3'd1);
        return vc[{3'd7 - k, 3'b000} +: 8];
    endfunction

`ifdef ENC_CHECK_EN
    function automatic logic f_bad(input logic [3:0] ic, input logic [3:0] fn);
        if (ic > 4'd11)                 return 1'b1;
        if (ic == 4'd2 || ic == 4'd7)   return fn > 4'd6;
        if (ic == 4'd6)                 return fn > 4'd3;
        return fn != 4'd0;
    endfunction

    assign w_bad = f_bad(icode, ifun);
`else
    assign w_bad = 1'b0;
`endif

    assign w_len  = f_len(icode);
    assign w_sum  = r_wr_addr + {{(ADDR_W-3){1'b0}}, w_len};
    assign w_full = {1'b1, {ADDR_W{1'b0}}};
    assign w_ovf  = w_sum > w_full;

    assign in_ready  = (r_state == IDLE) && !base_load;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign wr_addr   = r_wr_addr;
    assign done      = r_done;
    assign err       = r_err;
    assign dbg_state = r_state;

    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_idx     = r_idx;
        w_nxt_we      = 1'b0;
        w_nxt_addr    = r_mem_addr;
        w_nxt_wdata   = r_mem_wdata;
        w_nxt_wr_addr = r_wr_addr;
        w_nxt_done    = 1'b0;
        w_nxt_err     = r_err;
        w_cap         = 1'b0;
        case (r_state)
            IDLE: begin
                if (base_load) begin
                    w_nxt_wr_addr = {1'b0, base_addr};
                    w_nxt_err     = 1'b0;
                end else if (in_valid) begin
                    if (w_ovf || w_bad) begin
                        w_nxt_err = 1'b1;
                    end else begin
                        w_cap       = 1'b1;
                        w_nxt_state = EMIT;
                        w_nxt_idx   = 4'd0;
                        w_nxt_we    = 1'b1;
                        w_nxt_addr  = r_wr_addr[ADDR_W-1:0];
                        w_nxt_wdata = {icode, ifun};
                        w_nxt_done  = (w_len == 4'd1);
                    end
                end
            end
            EMIT: begin
                if (r_idx == r_len - 4'd1) begin
                    w_nxt_state   = IDLE;
                    w_nxt_wr_addr = r_wr_addr + {{(ADDR_W-3){1'b0}}, r_len};
                end else begin
                    w_nxt_idx   = r_idx + 4'd1;
                    w_nxt_we    = 1'b1;
                    w_nxt_addr  = r_mem_addr + 1'b1;
                    w_nxt_wdata = f_byte(r_idx + 4'd1, r_icode, r_ifun, r_ra, r_rb, r_valc);
                    w_nxt_done  = (r_idx + 4'd2 == r_len);
                end
            end
            default: w_nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= 4'd0;
            r_len       <= 4'd0;
            r_icode     <= 4'd0;
            r_ifun      <= 4'd0;
            r_ra        <= 4'd0;
            r_rb        <= 4'd0;
            r_valc      <= 64'd0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 8'd0;
            r_wr_addr   <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_idx       <= w_nxt_idx;
            r_mem_we    <= w_nxt_we;
            r_mem_addr  <= w_nxt_addr;
            r_mem_wdata <= w_nxt_wdata;
            r_wr_addr   <= w_nxt_wr_addr;
            r_done      <= w_nxt_done;
            r_err       <= w_nxt_err;
            if (w_cap) begin
                r_len   <= w_len;
                r_icode <= icode;
                r_ifun  <= ifun;
                r_ra    <= rA;
                r_rb    <= rB;
                r_valc  <= valC;
            end
        end
    end

endmodule
